// File: rtl/modmul_pipe.sv
// Three-stage pipelined modular multiplier, m = (a*b) mod (2^W - C).
// Reduction folds the high part twice and finishes with one conditional subtract.
module modmul_pipe #(
  parameter int unsigned W     = 5,
  parameter int unsigned C     = 3,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     m,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned M  = (2 ** W) - C;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned SW = 2 * W + 1;

  // Reject moduli for which two folds plus one subtract cannot fully reduce.
  generate
    if ((C < 1) || ((C * (C + 2)) >= (2 ** W))) begin : g_bad_modulus
      $error("modmul_pipe: illegal modulus offset C=%0d for W=%0d", C, W);
    end
    if (TAG_W < 1) begin : g_bad_tag
      $error("modmul_pipe: TAG_W must be at least 1");
    end
  endgenerate

  logic             v1, v2, v3;
  logic             en1, en2, en3;
  logic [PW-1:0]    p1;
  logic [SW-1:0]    s0_2;
  logic [TAG_W-1:0] tag1, tag2;

  logic [PW-1:0]    p_c;
  logic [SW-1:0]    s0_c;
  logic [SW-1:0]    s1_c;
  logic [W-1:0]     m_c;

  // Bubble-collapsing enables; in_ready never looks at in_valid.
  assign en3       = ~v3 | out_ready;
  assign en2       = ~v2 | en3;
  assign en1       = ~v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  assign p_c  = PW'(a) * PW'(b);
  assign s0_c = SW'(p1[W-1:0]) + SW'(p1[PW-1:W]) * SW'(C);
  assign s1_c = SW'(s0_2[W-1:0]) + SW'(s0_2[SW-1:W]) * SW'(C);
  assign m_c  = (s1_c >= SW'(M)) ? W'(s1_c - SW'(M)) : W'(s1_c);

  // Each stage loads its data only when enabled and the upstream slot is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      p1      <= '0;
      s0_2    <= '0;
      tag1    <= '0;
      tag2    <= '0;
      m       <= '0;
      out_tag <= '0;
    end else begin
      if (en1) begin
        v1 <= in_valid;
        if (in_valid) begin
          p1   <= p_c;
          tag1 <= in_tag;
        end
      end
      if (en2) begin
        v2 <= v1;
        if (v1) begin
          s0_2 <= s0_c;
          tag2 <= tag1;
        end
      end
      if (en3) begin
        v3 <= v2;
        if (v2) begin
          m       <= m_c;
          out_tag <= tag2;
        end
      end
    end
  end

endmodule

// File: tb/tb_modmul_pipe.sv
// Directed and exhaustive checks of modmul_pipe: mod-29 unit plus W=8 instances (C=5, C=12).
module tb_modmul_pipe;

  logic       clk = 1'b0;
  logic       reset;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [4:0] a, b, m;
  logic [3:0] in_tag, out_tag;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] a8, b8, m8;
  logic [3:0] in_tag8, out_tag8;

  logic       in_valid12, in_ready12, out_valid12, out_ready12;
  logic [7:0] a12, b12, m12;
  logic [3:0] in_tag12, out_tag12;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] m;
    logic [3:0] tag;
  } exp_t;

  modmul_pipe #(.W(5), .C(3), .TAG_W(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .m(m), .out_tag(out_tag)
  );

  modmul_pipe #(.W(8), .C(5), .TAG_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .in_tag(in_tag8), .out_valid(out_valid8), .out_ready(out_ready8),
    .m(m8), .out_tag(out_tag8)
  );

  modmul_pipe #(.W(8), .C(12), .TAG_W(4)) u_dut12 (
    .clk(clk), .reset(reset), .in_valid(in_valid12), .in_ready(in_ready12),
    .a(a12), .b(b12), .in_tag(in_tag12), .out_valid(out_valid12), .out_ready(out_ready12),
    .m(m12), .out_tag(out_tag12)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_all;
    in_valid    = 1'b0; a   = '0; b   = '0; in_tag   = '0; out_ready   = 1'b1;
    in_valid8   = 1'b0; a8  = '0; b8  = '0; in_tag8  = '0; out_ready8  = 1'b1;
    in_valid12  = 1'b0; a12 = '0; b12 = '0; in_tag12 = '0; out_ready12 = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || m !== 5'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b m=%0d tag=%0d required v=0 m=0 tag=0", out_valid, m, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    checks++;
    if (out_valid8 !== 1'b0 || m8 !== 8'd0 || in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL reset_w8 got v=%b m=%0d rdy=%b required v=0 m=0 rdy=1", out_valid8, m8, in_ready8);
    end
  endtask

  task automatic test_back_to_back;
    int va [5];
    int vb [5];
    int vm [5];
    va = '{31, 28, 29, 0, 30};
    vb = '{31, 28, 1, 17, 2};
    vm = '{4, 1, 0, 0, 2};
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready cyc=%0d got %b required 1", cyc, in_ready);
      end
      checks++;
      if (cyc >= 3 && cyc < 8) begin
        if (out_valid !== 1'b1 || m !== 5'(vm[cyc-3]) || out_tag !== 4'(cyc - 3 + 8)) begin
          errors++;
          $display("FAIL b2b_result cyc=%0d got v=%b m=%0d tag=%0d required v=1 m=%0d tag=%0d",
                   cyc, out_valid, m, out_tag, vm[cyc-3], cyc - 3 + 8);
        end
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_no_valid cyc=%0d got v=%b required 0", cyc, out_valid);
      end
      if (cyc < 5) begin
        in_valid = 1'b1;
        a        = 5'(va[cyc]);
        b        = 5'(vb[cyc]);
        in_tag   = 4'(cyc + 8);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    int pa [5];
    int vm [5];
    int idx = 0;
    int nxt = 0;
    int budget = 0;
    logic acc;
    pa = '{3, 4, 5, 6, 7};
    vm = '{1, 11, 21, 2, 12};
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a        = 5'(pa[idx]);
      b        = 5'd10;
      in_tag   = 4'(idx + 1);
      #1;
      acc = in_ready;
      if (cyc >= 3) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1 || m !== 5'd1) begin
          errors++;
          $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b m=%0d tag=%0d required rdy=0 v=1 m=1 tag=1",
                   cyc, in_ready, out_valid, m, out_tag);
        end
      end
      @(posedge clk);
      if (acc) idx++;
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL bp_accepted got %0d required 3", idx);
    end
    while (nxt < 5 && budget < 30) begin
      @(negedge clk);
      budget++;
      out_ready = 1'b1;
      if (idx < 5) begin
        in_valid = 1'b1;
        a        = 5'(pa[idx]);
        b        = 5'd10;
        in_tag   = 4'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (m !== 5'(vm[nxt]) || out_tag !== 4'(nxt + 1)) begin
          errors++;
          $display("FAIL bp_drain_order n=%0d got m=%0d tag=%0d required m=%0d tag=%0d",
                   nxt, m, out_tag, vm[nxt], nxt + 1);
        end
        nxt++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    checks++;
    if (nxt != 5 || idx != 5) begin
      errors++;
      $display("FAIL bp_drain_count got out=%0d in=%0d required 5 and 5", nxt, idx);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_duplicate got v=%b required 0", out_valid);
    end
  endtask

  task automatic test_full_throughput;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(negedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL tp_in_ready cyc=%0d got %b required 1", cyc, in_ready);
      end
      if (cyc >= 3) begin
        checks++;
        if (out_valid !== 1'b1 || m !== 5'(((cyc - 3 + 20) * (cyc - 3 + 11)) % 29) ||
            out_tag !== 4'(cyc - 3)) begin
          errors++;
          $display("FAIL tp_result cyc=%0d got v=%b m=%0d tag=%0d required v=1 m=%0d tag=%0d",
                   cyc, out_valid, m, out_tag, ((cyc - 3 + 20) * (cyc - 3 + 11)) % 29, cyc - 3);
        end
      end
      if (cyc < 10) begin
        in_valid = 1'b1;
        a        = 5'(cyc + 20);
        b        = 5'(cyc + 11);
        in_tag   = 4'(cyc);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_exhaustive;
    exp_t q[$];
    exp_t e;
    int sent = 0;
    int got = 0;
    int budget = 0;
    int av = 0;
    int bv = 0;
    logic acc;
    while ((sent < 1024 || got < 1024) && budget < 20000) begin
      @(negedge clk);
      budget++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 1024) begin
        in_valid = ($urandom_range(0, 3) != 0);
        av       = sent / 32;
        bv       = sent % 32;
        a        = 5'(av);
        b        = 5'(bv);
        in_tag   = 4'(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL exh_extra got m=%0d tag=%0d required no output", m, out_tag);
        end else begin
          e = q.pop_front();
          if (m !== e.m || out_tag !== e.tag) begin
            errors++;
            $display("FAIL exh_result n=%0d got m=%0d tag=%0d required m=%0d tag=%0d",
                     got, m, out_tag, e.m, e.tag);
          end
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        e.m   = 5'((av * bv) % 29);
        e.tag = 4'(sent);
        q.push_back(e);
        sent++;
      end
    end
    checks++;
    if (got != 1024 || q.size() != 0) begin
      errors++;
      $display("FAIL exh_count got out=%0d pending=%0d required 1024 and 0", got, q.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 5'd31; b = 5'd31; in_tag = 4'd6;
    @(negedge clk);
    in_valid = 1'b1; a = 5'd28; b = 5'd28; in_tag = 4'd7;
    @(negedge clk);
    in_valid = 1'b1; a = 5'd5; b = 5'd5; in_tag = 4'd9;
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || m !== 5'd0 || out_tag !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got v=%b m=%0d tag=%0d rdy=%b required v=0 m=0 tag=0 rdy=1",
               out_valid, m, out_tag, in_ready);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_stale cyc=%0d got v=%b m=%0d tag=%0d required v=0",
                 cyc, out_valid, m, out_tag);
      end
    end
  endtask

  task automatic test_wide;
    int a8v [3];
    int b8v [3];
    int m8v [3];
    int a12v [3];
    int b12v [3];
    int m12v [3];
    a8v  = '{255, 250, 251};
    b8v  = '{255, 250, 7};
    m8v  = '{16, 1, 0};
    a12v = '{255, 243, 244};
    b12v = '{255, 2, 9};
    m12v = '{121, 242, 0};
    out_ready8  = 1'b1;
    out_ready12 = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc >= 3 && cyc < 6) begin
        checks++;
        if (out_valid8 !== 1'b1 || m8 !== 8'(m8v[cyc-3]) || out_tag8 !== 4'(cyc - 2)) begin
          errors++;
          $display("FAIL w8c5_result cyc=%0d got v=%b m=%0d tag=%0d required v=1 m=%0d tag=%0d",
                   cyc, out_valid8, m8, out_tag8, m8v[cyc-3], cyc - 2);
        end
        checks++;
        if (out_valid12 !== 1'b1 || m12 !== 8'(m12v[cyc-3]) || out_tag12 !== 4'(cyc + 2)) begin
          errors++;
          $display("FAIL w8c12_result cyc=%0d got v=%b m=%0d tag=%0d required v=1 m=%0d tag=%0d",
                   cyc, out_valid12, m12, out_tag12, m12v[cyc-3], cyc + 2);
        end
      end
      if (cyc < 3) begin
        in_valid8  = 1'b1; a8  = 8'(a8v[cyc]);  b8  = 8'(b8v[cyc]);  in_tag8  = 4'(cyc + 1);
        in_valid12 = 1'b1; a12 = 8'(a12v[cyc]); b12 = 8'(b12v[cyc]); in_tag12 = 4'(cyc + 5);
      end else begin
        in_valid8  = 1'b0;
        in_valid12 = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_full_throughput();
    test_exhaustive();
    test_mid_reset();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
